// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared widths, byte count and state encodings for the SRAM
//               address sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 24;
    localparam int ADDR_BYTES = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_LOAD   = 3'b001,
        ST_ACCESS = 3'b010,
        ST_INC    = 3'b011
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_addr_seq_sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer plus an edge flop for one async input;
//               provides the synchronized level and single-cycle rise/fall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       edge_q;
    logic       edge_d;

    always_comb begin
        sync_d = {sync_q[0], async_in};
        edge_d = sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            edge_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~edge_q;
    assign fall  = ~sync_q[1] & edge_q;

endmodule

`default_nettype wire

// File: rtl/sram_addr_seq.sv
// ============================================================================
// Module      : sram_addr_seq
// Description : Loads a 24-bit SRAM address as three AVR bus bytes, drives
//               chip-enable during accesses and auto-increments afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_addr_seq
    import sram_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int AWIDTH  = AWIDTH_DEF,
    parameter bit AUTOINC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] avr_data,
    input  logic              avr_ale,
    input  logic              avr_we,
    input  logic              avr_oe,
    output logic [AWIDTH-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              addr_wrap,
    output logic [2:0]        debug
);

    localparam logic [1:0] LAST_BYTE = 2'(ADDR_BYTES - 1);

    logic we_s, we_rise, we_fall_raw;
    logic oe_s, oe_rise, oe_fall_raw;
    logic ale_s, ale_rise_unused, ale_fall_raw;
    logic armed, we_fall, oe_fall, ale_fall;

    sync_edge u_sync_we (
        .clk      (clk),
        .reset    (reset),
        .async_in (avr_we),
        .level    (we_s),
        .rise     (we_rise),
        .fall     (we_fall_raw)
    );

    sync_edge u_sync_oe (
        .clk      (clk),
        .reset    (reset),
        .async_in (avr_oe),
        .level    (oe_s),
        .rise     (oe_rise),
        .fall     (oe_fall_raw)
    );

    sync_edge u_sync_ale (
        .clk      (clk),
        .reset    (reset),
        .async_in (avr_ale),
        .level    (ale_s),
        .rise     (ale_rise_unused),
        .fall     (ale_fall_raw)
    );

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] staging_q, staging_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]        settle_q, settle_d;
    logic              wrap_q, wrap_d;
    logic              ce_n_q, ce_n_d;
    logic              acc_we_q, acc_we_d;

    // Synchronizers reset high, so a strobe still held low through reset
    // would look like a fresh falling edge; ignore edges until they flush.
    assign armed    = (settle_q == 2'd3);
    assign we_fall  = we_fall_raw & armed;
    assign oe_fall  = oe_fall_raw & armed;
    assign ale_fall = ale_fall_raw & armed;

    always_comb begin
        state_d    = state_q;
        staging_d  = staging_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        wrap_d     = wrap_q;
        acc_we_d   = acc_we_q;
        settle_d   = armed ? settle_q : settle_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (ale_s && we_fall) begin
                    data_d  = avr_data;
                    state_d = ST_LOAD;
                end else if (!ale_s && we_fall && oe_s) begin
                    acc_we_d = 1'b1;
                    state_d  = ST_ACCESS;
                end else if (!ale_s && oe_fall && we_s) begin
                    acc_we_d = 1'b0;
                    state_d  = ST_ACCESS;
                end
            end
            ST_LOAD: begin
                staging_d = {staging_q[AWIDTH-DWIDTH-1:0], data_q};
                if (byte_cnt_q == LAST_BYTE) begin
                    addr_d     = staging_d;
                    byte_cnt_d = 2'd0;
                    wrap_d     = 1'b0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                if (acc_we_q ? we_rise : oe_rise) begin
                    state_d = ST_INC;
                end
            end
            ST_INC: begin
                if (AUTOINC) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == '1) begin
                        wrap_d = 1'b1;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Leaving the address phase mid-load abandons the partial address.
        if (ale_fall && (byte_cnt_d != 2'd0)) begin
            byte_cnt_d = 2'd0;
            staging_d  = '0;
        end

        ce_n_d = (state_d != ST_ACCESS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            staging_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= 2'd0;
            settle_q   <= 2'd0;
            wrap_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            acc_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            staging_q  <= staging_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            settle_q   <= settle_d;
            wrap_q     <= wrap_d;
            ce_n_q     <= ce_n_d;
            acc_we_q   <= acc_we_d;
        end
    end

    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign addr_wrap = wrap_q;
    assign debug     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_addr_seq.sv
// ============================================================================
// Module      : tb_sram_addr_seq
// Description : Directed vector bench for sram_addr_seq, AUTOINC=1 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_addr_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  avr_data = 8'h00;
    logic        avr_ale = 1'b0;
    logic        avr_we = 1'b1;
    logic        avr_oe = 1'b1;

    logic [23:0] sram_addr, sram_addr0;
    logic        sram_ce_n, sram_ce_n0;
    logic        addr_wrap, addr_wrap0;
    logic [2:0]  debug, debug0;

    int checks = 0;
    int errors = 0;

    logic       ce_mid;
    logic [2:0] dbg_mid;

    typedef struct {
        logic        ale;
        logic [1:0]  kind;      // 0 we, 1 oe, 2 both
        logic [7:0]  data;
        logic [23:0] exp_addr;
        logic        exp_wrap;
        logic        exp_ce_mid;
        logic [2:0]  exp_dbg_mid;
        logic [23:0] exp_addr0;
    } vec_t;

    vec_t vecs[21];

    always #5 clk = ~clk;

    sram_addr_seq #(.DWIDTH(8), .AWIDTH(24), .AUTOINC(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .avr_data  (avr_data),
        .avr_ale   (avr_ale),
        .avr_we    (avr_we),
        .avr_oe    (avr_oe),
        .sram_addr (sram_addr),
        .sram_ce_n (sram_ce_n),
        .addr_wrap (addr_wrap),
        .debug     (debug)
    );

    sram_addr_seq #(.DWIDTH(8), .AWIDTH(24), .AUTOINC(1'b0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .avr_data  (avr_data),
        .avr_ale   (avr_ale),
        .avr_we    (avr_we),
        .avr_oe    (avr_oe),
        .sram_addr (sram_addr0),
        .sram_ce_n (sram_ce_n0),
        .addr_wrap (addr_wrap0),
        .debug     (debug0)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [1:0] kind, input logic [7:0] d,
                          output logic ce_o, output logic [2:0] dbg_o);
        avr_data = d;
        if (kind != 2'd1) avr_we = 1'b0;
        if (kind != 2'd0) avr_oe = 1'b0;
        tick(5);
        ce_o  = sram_ce_n;
        dbg_o = debug;
        avr_we = 1'b1;
        avr_oe = 1'b1;
        tick(6);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 8'h12, 24'h000000, 1'b0, 1'b1, 3'd0, 24'h000000};
        vecs[1]  = '{1'b1, 2'd0, 8'h34, 24'h000000, 1'b0, 1'b1, 3'd0, 24'h000000};
        vecs[2]  = '{1'b1, 2'd0, 8'h56, 24'h123456, 1'b0, 1'b1, 3'd0, 24'h123456};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 24'h123457, 1'b0, 1'b0, 3'd2, 24'h123456};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 24'h123458, 1'b0, 1'b0, 3'd2, 24'h123456};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 24'h123459, 1'b0, 1'b0, 3'd2, 24'h123456};
        vecs[6]  = '{1'b0, 2'd1, 8'h00, 24'h12345A, 1'b0, 1'b0, 3'd2, 24'h123456};
        vecs[7]  = '{1'b0, 2'd2, 8'h00, 24'h12345A, 1'b0, 1'b1, 3'd0, 24'h123456};
        vecs[8]  = '{1'b1, 2'd0, 8'hFF, 24'h12345A, 1'b0, 1'b1, 3'd0, 24'h123456};
        vecs[9]  = '{1'b1, 2'd0, 8'hFF, 24'h12345A, 1'b0, 1'b1, 3'd0, 24'h123456};
        vecs[10] = '{1'b1, 2'd0, 8'hFF, 24'hFFFFFF, 1'b0, 1'b1, 3'd0, 24'hFFFFFF};
        vecs[11] = '{1'b0, 2'd1, 8'h00, 24'h000000, 1'b1, 1'b0, 3'd2, 24'hFFFFFF};
        vecs[12] = '{1'b1, 2'd0, 8'h00, 24'h000000, 1'b1, 1'b1, 3'd0, 24'hFFFFFF};
        vecs[13] = '{1'b1, 2'd0, 8'h00, 24'h000000, 1'b1, 1'b1, 3'd0, 24'hFFFFFF};
        vecs[14] = '{1'b1, 2'd0, 8'h10, 24'h000010, 1'b0, 1'b1, 3'd0, 24'h000010};
        vecs[15] = '{1'b1, 2'd0, 8'hAB, 24'h000010, 1'b0, 1'b1, 3'd0, 24'h000010};
        vecs[16] = '{1'b1, 2'd0, 8'hCD, 24'h000010, 1'b0, 1'b1, 3'd0, 24'h000010};
        vecs[17] = '{1'b0, 2'd1, 8'h00, 24'h000011, 1'b0, 1'b0, 3'd2, 24'h000010};
        vecs[18] = '{1'b1, 2'd0, 8'h11, 24'h000011, 1'b0, 1'b1, 3'd0, 24'h000010};
        vecs[19] = '{1'b1, 2'd0, 8'h22, 24'h000011, 1'b0, 1'b1, 3'd0, 24'h000010};
        vecs[20] = '{1'b1, 2'd0, 8'h33, 24'h112233, 1'b0, 1'b1, 3'd0, 24'h112233};

        tick(3);
        reset = 1'b0;
        chk("rst addr", 32'(sram_addr), 32'h0);
        chk("rst ce_n", 32'(sram_ce_n), 32'h1);
        chk("rst wrap", 32'(addr_wrap), 32'h0);
        chk("rst debug", 32'(debug), 32'h0);
        chk("rst addr0", 32'(sram_addr0), 32'h0);

        for (int i = 0; i < 21; i++) begin
            if (avr_ale !== vecs[i].ale) begin
                avr_ale = vecs[i].ale;
                tick(4);
            end
            strobe(vecs[i].kind, vecs[i].data, ce_mid, dbg_mid);
            chk($sformatf("v%0d ce_mid", i), 32'(ce_mid), 32'(vecs[i].exp_ce_mid));
            chk($sformatf("v%0d dbg_mid", i), 32'(dbg_mid), 32'(vecs[i].exp_dbg_mid));
            chk($sformatf("v%0d addr", i), 32'(sram_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d wrap", i), 32'(addr_wrap), 32'(vecs[i].exp_wrap));
            chk($sformatf("v%0d ce_end", i), 32'(sram_ce_n), 32'h1);
            chk($sformatf("v%0d addr0", i), 32'(sram_addr0), 32'(vecs[i].exp_addr0));
            chk($sformatf("v%0d wrap0", i), 32'(addr_wrap0), 32'h0);
        end

        // Reset while an access is in progress, strobe still held low.
        avr_ale = 1'b0;
        tick(4);
        avr_we = 1'b0;
        tick(5);
        chk("acc debug", 32'(debug), 32'h2);
        chk("acc ce_n", 32'(sram_ce_n), 32'h0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid rst ce_n", 32'(sram_ce_n), 32'h1);
        chk("mid rst addr", 32'(sram_addr), 32'h0);
        chk("mid rst debug", 32'(debug), 32'h0);
        chk("mid rst addr0", 32'(sram_addr0), 32'h0);
        tick(4);
        chk("held we ce_n", 32'(sram_ce_n), 32'h1);
        avr_we = 1'b1;
        tick(6);
        chk("post rel addr", 32'(sram_addr), 32'h0);
        chk("post rel debug", 32'(debug), 32'h0);
        chk("post rel wrap", 32'(addr_wrap), 32'h0);

        // A fresh access after the reset still works.
        strobe(2'd1, 8'h00, ce_mid, dbg_mid);
        chk("post rst ce_mid", 32'(ce_mid), 32'h0);
        chk("post rst addr", 32'(sram_addr), 32'h1);
        chk("post rst addr0", 32'(sram_addr0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
